// File: rtl/flasher_pkg.sv
// Shared encodings for the bound flasher monitor: monitor states, error
// codes, per-segment bounds and kickback levels.
package flasher_pkg;

  // Monitor state encodings (kept as plain constants for legacy users).
  localparam logic [1:0] MS_IDLE   = 2'd0;
  localparam logic [1:0] MS_UP     = 2'd1;
  localparam logic [1:0] MS_DOWN   = 2'd2;
  localparam logic [1:0] MS_RESYNC = 2'd3;

  // Error codes; priority high->low is CODE, STEP, RANGE, TURN, STALL.
  typedef enum logic [2:0] {
    EC_NONE  = 3'd0,
    EC_CODE  = 3'd1,
    EC_STEP  = 3'd2,
    EC_TURN  = 3'd3,
    EC_STALL = 3'd4,
    EC_RANGE = 3'd5
  } err_code_t;

  // Turning points of each segment of the trajectory 0->16->5->11->0->6->0.
  localparam logic [4:0] SEG_MAX [3] = '{5'd16, 5'd11, 5'd6};
  localparam logic [4:0] SEG_MIN [3] = '{5'd5,  5'd0,  5'd0};

  // Levels at which a hold is accepted as a kickback.
  localparam logic [4:0] KB_LO = 5'd0;
  localparam logic [4:0] KB_HI = 5'd5;

  // Upper bound of a segment; segment 3 never occurs and maps to segment 2.
  function automatic logic [4:0] seg_max(input logic [1:0] seg);
    case (seg)
      2'd0:    return SEG_MAX[0];
      2'd1:    return SEG_MAX[1];
      default: return SEG_MAX[2];
    endcase
  endfunction

  // Lower bound of a segment; segment 3 never occurs and maps to segment 2.
  function automatic logic [4:0] seg_min(input logic [1:0] seg);
    case (seg)
      2'd0:    return SEG_MIN[0];
      2'd1:    return SEG_MIN[1];
      default: return SEG_MIN[2];
    endcase
  endfunction

endpackage

// File: rtl/therm_decode.sv
// Combinational thermometer decoder: a bar is valid when it is a run of ones
// starting at bit 0; the level is the popcount of the raw bar.
module therm_decode #(
  parameter int LED_W = 16
) (
  input  logic [LED_W-1:0] LED,
  output logic             VALID,
  output logic [4:0]       LEVEL
);

  // Valid iff adding one clears every set bit (no hole in the bar).
  always_comb begin
    VALID = ((LED & (LED + LED_W'(1))) == '0);
  end

  // Popcount of the raw bar, reported even when the code is invalid.
  always_comb begin
    LEVEL = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      LEVEL = LEVEL + 5'(LED[i]);
    end
  end

endmodule

// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound flasher: tracks level, segment and direction
// along 0->16->5->11->0->6->0 and flags illegal samples.
// Optional: define FLASHER_MON_COV_EN to add the KICK_CNT coverage counter.
module bound_flasher_monitor
  import flasher_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLICK,
  input  logic [LED_W-1:0] LED,
  output logic [4:0]       LEVEL,
  output logic [1:0]       MSTATE,
  output logic [1:0]       SEG,
  output logic             ERR,
  output logic [2:0]       ERR_CODE,
  output logic [CNT_W-1:0] DONE_CNT
`ifdef FLASHER_MON_COV_EN
  ,
  output logic [CNT_W-1:0] KICK_CNT
`endif
);

  logic       valid;
  logic [4:0] cur;
  logic [4:0] prev;
  logic       step_up;
  logic       step_dn;
  logic       hold;
  logic [1:0] nstate;
  logic [1:0] nseg;
  err_code_t  ec;
  logic       done;
`ifdef FLASHER_MON_COV_EN
  logic       kick;
`endif

  therm_decode #(.LED_W(LED_W)) u_dec (
    .LED   (LED),
    .VALID (valid),
    .LEVEL (cur)
  );

  // The previously sampled level is the registered LEVEL output.
  assign prev = LEVEL;

  // Classify the step and compute next state, segment and error code.
  always_comb begin
    nstate  = MSTATE;
    nseg    = SEG;
    ec      = EC_NONE;
    done    = 1'b0;
`ifdef FLASHER_MON_COV_EN
    kick    = 1'b0;
`endif
    step_up = (cur == prev + 5'd1);
    step_dn = (prev != '0) && (cur == prev - 5'd1);
    hold    = (cur == prev);

    case (MSTATE)
      MS_IDLE: begin
        if (!valid) begin
          ec = EC_CODE;
        end else if (cur == 5'd1) begin
          nstate = MS_UP;
          nseg   = 2'd0;
        end else if (cur != 5'd0) begin
          ec = EC_STEP;
        end
      end

      MS_UP: begin
        if (!valid) begin
          ec = EC_CODE;
        end else if (!(step_up || step_dn || hold)) begin
          ec = EC_STEP;
        end else if (step_up) begin
          if (cur > seg_max(SEG)) ec = EC_RANGE;
        end else if (step_dn) begin
          if (prev == seg_max(SEG)) nstate = MS_DOWN;
          else                      ec     = EC_TURN;
        end else begin
          ec = EC_STALL;
        end
      end

      MS_DOWN: begin
        if (!valid) begin
          ec = EC_CODE;
        end else if (!(step_up || step_dn || hold)) begin
          ec = EC_STEP;
        end else if (step_dn) begin
          if (cur < seg_min(SEG)) ec = EC_RANGE;
        end else if (step_up) begin
          if ((prev == seg_min(SEG)) && (SEG < 2'd2)) begin
            nstate = MS_UP;
            nseg   = SEG + 2'd1;
          end else begin
            ec = EC_TURN;
          end
        end else if ((prev == KB_LO) && (SEG == 2'd2) && !FLICK) begin
          nstate = MS_IDLE;
          nseg   = 2'd0;
          done   = 1'b1;
        end else if ((prev == KB_LO) || (prev == KB_HI)) begin
          nstate = MS_UP;
          nseg   = (SEG == 2'd0) ? 2'd0 : SEG - 2'd1;
`ifdef FLASHER_MON_COV_EN
          kick   = 1'b1;
`endif
        end else begin
          ec = EC_STALL;
        end
      end

      default: begin
        if (valid && (cur == 5'd0)) begin
          nstate = MS_IDLE;
          nseg   = 2'd0;
        end
      end
    endcase

    // Any error abandons tracking; the segment is left where it was.
    if (ec != EC_NONE) begin
      nstate = MS_RESYNC;
      nseg   = SEG;
      done   = 1'b0;
`ifdef FLASHER_MON_COV_EN
      kick   = 1'b0;
`endif
    end
  end

  // Register level, state, segment, error pulse and the sticky first error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEVEL    <= '0;
      MSTATE   <= MS_IDLE;
      SEG      <= 2'd0;
      ERR      <= 1'b0;
      ERR_CODE <= '0;
    end else begin
      LEVEL  <= cur;
      MSTATE <= nstate;
      SEG    <= nseg;
      ERR    <= (ec != EC_NONE);
      if ((ec != EC_NONE) && (ERR_CODE == '0)) ERR_CODE <= ec;
    end
  end

  // Completed-run counter, wraps at 2^CNT_W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       DONE_CNT <= '0;
    else if (done) DONE_CNT <= DONE_CNT + CNT_W'(1);
  end

`ifdef FLASHER_MON_COV_EN
  // Accepted-kickback counter, wraps at 2^CNT_W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       KICK_CNT <= '0;
    else if (kick) KICK_CNT <= KICK_CNT + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed bench for bound_flasher_monitor with hand-computed expectations.
module tb_bound_flasher_monitor;

  logic        CLK;
  logic        RST;
  logic        FLICK;
  logic [15:0] LED;
  logic [4:0]  LEVEL;
  logic [1:0]  MSTATE;
  logic [1:0]  SEG;
  logic        ERR;
  logic [2:0]  ERR_CODE;
  logic [7:0]  DONE_CNT;
`ifdef FLASHER_MON_COV_EN
  logic [7:0]  KICK_CNT;
`endif

  int n_vec = 0;
  int n_err = 0;

  bound_flasher_monitor #(.LED_W(16), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .FLICK    (FLICK),
    .LED      (LED),
    .LEVEL    (LEVEL),
    .MSTATE   (MSTATE),
    .SEG      (SEG),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE),
    .DONE_CNT (DONE_CNT)
`ifdef FLASHER_MON_COV_EN
    ,
    .KICK_CNT (KICK_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Drive one thermometer level, then settle just after the sampling edge.
  task automatic go(input int lvl, input logic fl);
    logic [16:0] t;
    t = (17'd1 << lvl) - 17'd1;
    LED   = t[15:0];
    FLICK = fl;
    @(posedge CLK);
    #1;
  endtask

  task automatic ramp(input int a, input int b);
    if (a <= b) for (int v = a; v <= b; v++) go(v, 1'b0);
    else        for (int v = a; v >= b; v--) go(v, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1; LED = '0; FLICK = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; LED = 16'h00ff; FLICK = 1'b1;
    @(posedge CLK); #1;
    n_vec++; if (MSTATE !== 2'd0)   begin n_err++; $display("FAIL rst_mstate: got %0d exp 0", MSTATE); end
    n_vec++; if (SEG !== 2'd0)      begin n_err++; $display("FAIL rst_seg: got %0d exp 0", SEG); end
    n_vec++; if (LEVEL !== 5'd0)    begin n_err++; $display("FAIL rst_level: got %0d exp 0", LEVEL); end
    n_vec++; if (ERR !== 1'b0)      begin n_err++; $display("FAIL rst_err: got %0d exp 0", ERR); end
    n_vec++; if (ERR_CODE !== 3'd0) begin n_err++; $display("FAIL rst_code: got %0d exp 0", ERR_CODE); end
    n_vec++; if (DONE_CNT !== 8'd0) begin n_err++; $display("FAIL rst_done: got %0d exp 0", DONE_CNT); end
`ifdef FLASHER_MON_COV_EN
    n_vec++; if (KICK_CNT !== 8'd0) begin n_err++; $display("FAIL rst_kick: got %0d exp 0", KICK_CNT); end
`endif
    RST = 1'b0; LED = '0; FLICK = 1'b0;
  endtask

  task automatic test_full_run();
    int lv[$]; int st[$]; int sg[$];
    do_reset();
    lv.push_back(0); st.push_back(0); sg.push_back(0);
    for (int v = 1;  v <= 16; v++) begin lv.push_back(v); st.push_back(1); sg.push_back(0); end
    for (int v = 15; v >= 5;  v--) begin lv.push_back(v); st.push_back(2); sg.push_back(0); end
    for (int v = 6;  v <= 11; v++) begin lv.push_back(v); st.push_back(1); sg.push_back(1); end
    for (int v = 10; v >= 0;  v--) begin lv.push_back(v); st.push_back(2); sg.push_back(1); end
    for (int v = 1;  v <= 6;  v++) begin lv.push_back(v); st.push_back(1); sg.push_back(2); end
    for (int v = 5;  v >= 0;  v--) begin lv.push_back(v); st.push_back(2); sg.push_back(2); end
    lv.push_back(0); st.push_back(0); sg.push_back(0);
    foreach (lv[i]) begin
      go(lv[i], 1'b0);
      n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL run_err[%0d]: got %0d exp 0", i, ERR); end
      n_vec++; if (LEVEL !== 5'(lv[i])) begin n_err++; $display("FAIL run_level[%0d]: got %0d exp %0d", i, LEVEL, lv[i]); end
      n_vec++; if (MSTATE !== 2'(st[i])) begin n_err++; $display("FAIL run_mstate[%0d]: got %0d exp %0d", i, MSTATE, st[i]); end
      n_vec++; if (SEG !== 2'(sg[i])) begin n_err++; $display("FAIL run_seg[%0d]: got %0d exp %0d", i, SEG, sg[i]); end
    end
    n_vec++; if (DONE_CNT !== 8'd1) begin n_err++; $display("FAIL run_done: got %0d exp 1", DONE_CNT); end
    n_vec++; if (ERR_CODE !== 3'd0) begin n_err++; $display("FAIL run_code: got %0d exp 0", ERR_CODE); end
  endtask

  task automatic test_kick_seg0();
    do_reset();
    ramp(0, 16); ramp(15, 5);
    go(5, 1'b1);
    n_vec++; if (MSTATE !== 2'd1) begin n_err++; $display("FAIL kick0_mstate: got %0d exp 1", MSTATE); end
    n_vec++; if (SEG !== 2'd0)    begin n_err++; $display("FAIL kick0_seg: got %0d exp 0", SEG); end
    n_vec++; if (ERR !== 1'b0)    begin n_err++; $display("FAIL kick0_err: got %0d exp 0", ERR); end
    for (int v = 6; v <= 16; v++) begin
      go(v, 1'b0);
      n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL kick0_climb_err[%0d]: got %0d exp 0", v, ERR); end
    end
    n_vec++; if (SEG !== 2'd0)      begin n_err++; $display("FAIL kick0_seg_end: got %0d exp 0", SEG); end
    n_vec++; if (ERR_CODE !== 3'd0) begin n_err++; $display("FAIL kick0_code: got %0d exp 0", ERR_CODE); end
`ifdef FLASHER_MON_COV_EN
    n_vec++; if (KICK_CNT !== 8'd1) begin n_err++; $display("FAIL kick0_cnt: got %0d exp 1", KICK_CNT); end
`endif
    go(15, 1'b0);
    n_vec++; if (MSTATE !== 2'd2) begin n_err++; $display("FAIL kick0_turn: got %0d exp 2", MSTATE); end
  endtask

  task automatic test_kick_seg2();
    do_reset();
    ramp(0, 16); ramp(15, 5); ramp(6, 11); ramp(10, 0); ramp(1, 6); ramp(5, 0);
    n_vec++; if (SEG !== 2'd2) begin n_err++; $display("FAIL kick2_pre_seg: got %0d exp 2", SEG); end
    go(0, 1'b1);
    n_vec++; if (MSTATE !== 2'd1)   begin n_err++; $display("FAIL kick2_mstate: got %0d exp 1", MSTATE); end
    n_vec++; if (SEG !== 2'd1)      begin n_err++; $display("FAIL kick2_seg: got %0d exp 1", SEG); end
    n_vec++; if (DONE_CNT !== 8'd0) begin n_err++; $display("FAIL kick2_done: got %0d exp 0", DONE_CNT); end
    go(1, 1'b0);
    n_vec++; if (MSTATE !== 2'd1) begin n_err++; $display("FAIL kick2_up_mstate: got %0d exp 1", MSTATE); end
    n_vec++; if (SEG !== 2'd1)    begin n_err++; $display("FAIL kick2_up_seg: got %0d exp 1", SEG); end
    n_vec++; if (ERR !== 1'b0)    begin n_err++; $display("FAIL kick2_up_err: got %0d exp 0", ERR); end
    ramp(2, 11); go(10, 1'b0);
    n_vec++; if (MSTATE !== 2'd2)   begin n_err++; $display("FAIL kick2_peak: got %0d exp 2", MSTATE); end
    n_vec++; if (ERR_CODE !== 3'd0) begin n_err++; $display("FAIL kick2_code: got %0d exp 0", ERR_CODE); end
  endtask

  task automatic test_code_err();
    do_reset();
    ramp(0, 2);
    LED = 16'h0005; FLICK = 1'b0;
    @(posedge CLK); #1;
    n_vec++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL code_err: got %0d exp 1", ERR); end
    n_vec++; if (ERR_CODE !== 3'd1) begin n_err++; $display("FAIL code_code: got %0d exp 1", ERR_CODE); end
    n_vec++; if (MSTATE !== 2'd3)   begin n_err++; $display("FAIL code_mstate: got %0d exp 3", MSTATE); end
    n_vec++; if (LEVEL !== 5'd2)    begin n_err++; $display("FAIL code_level: got %0d exp 2", LEVEL); end
    go(7, 1'b0);
    n_vec++; if (ERR !== 1'b0)    begin n_err++; $display("FAIL resync_err: got %0d exp 0", ERR); end
    n_vec++; if (MSTATE !== 2'd3) begin n_err++; $display("FAIL resync_hold: got %0d exp 3", MSTATE); end
    go(0, 1'b0);
    n_vec++; if (MSTATE !== 2'd0)   begin n_err++; $display("FAIL resync_idle: got %0d exp 0", MSTATE); end
    n_vec++; if (ERR_CODE !== 3'd1) begin n_err++; $display("FAIL resync_code: got %0d exp 1", ERR_CODE); end
  endtask

  task automatic test_turn_stall();
    do_reset();
    ramp(0, 9); go(8, 1'b0);
    n_vec++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL turn_err: got %0d exp 1", ERR); end
    n_vec++; if (ERR_CODE !== 3'd3) begin n_err++; $display("FAIL turn_code: got %0d exp 3", ERR_CODE); end
    n_vec++; if (MSTATE !== 2'd3)   begin n_err++; $display("FAIL turn_mstate: got %0d exp 3", MSTATE); end
    go(8, 1'b0);
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL turn_pulse: got %0d exp 0", ERR); end
    go(0, 1'b0); go(1, 1'b0); go(1, 1'b0);
    n_vec++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL stall_err: got %0d exp 1", ERR); end
    n_vec++; if (ERR_CODE !== 3'd3) begin n_err++; $display("FAIL stall_sticky: got %0d exp 3", ERR_CODE); end
    n_vec++; if (MSTATE !== 2'd3)   begin n_err++; $display("FAIL stall_mstate: got %0d exp 3", MSTATE); end
  endtask

  task automatic test_step_range();
    do_reset();
    go(0, 1'b0); go(3, 1'b0);
    n_vec++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL step_err: got %0d exp 1", ERR); end
    n_vec++; if (ERR_CODE !== 3'd2) begin n_err++; $display("FAIL step_code: got %0d exp 2", ERR_CODE); end
    do_reset();
    ramp(0, 16); ramp(15, 5); go(4, 1'b0);
    n_vec++; if (ERR !== 1'b1)      begin n_err++; $display("FAIL range_err: got %0d exp 1", ERR); end
    n_vec++; if (ERR_CODE !== 3'd5) begin n_err++; $display("FAIL range_code: got %0d exp 5", ERR_CODE); end
    go(3, 1'b0);
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL range_pulse: got %0d exp 0", ERR); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    ramp(0, 12);
    n_vec++; if (LEVEL !== 5'd12) begin n_err++; $display("FAIL mid_pre_level: got %0d exp 12", LEVEL); end
    #2; RST = 1'b1; #1;
    n_vec++; if (MSTATE !== 2'd0)   begin n_err++; $display("FAIL mid_mstate: got %0d exp 0", MSTATE); end
    n_vec++; if (SEG !== 2'd0)      begin n_err++; $display("FAIL mid_seg: got %0d exp 0", SEG); end
    n_vec++; if (LEVEL !== 5'd0)    begin n_err++; $display("FAIL mid_level: got %0d exp 0", LEVEL); end
    n_vec++; if (ERR !== 1'b0)      begin n_err++; $display("FAIL mid_err: got %0d exp 0", ERR); end
    n_vec++; if (ERR_CODE !== 3'd0) begin n_err++; $display("FAIL mid_code: got %0d exp 0", ERR_CODE); end
    n_vec++; if (DONE_CNT !== 8'd0) begin n_err++; $display("FAIL mid_done: got %0d exp 0", DONE_CNT); end
    #2; RST = 1'b0;
    go(0, 1'b0); go(1, 1'b0);
    n_vec++; if (ERR !== 1'b0)    begin n_err++; $display("FAIL post_err: got %0d exp 0", ERR); end
    n_vec++; if (MSTATE !== 2'd1) begin n_err++; $display("FAIL post_mstate: got %0d exp 1", MSTATE); end
    n_vec++; if (LEVEL !== 5'd1)  begin n_err++; $display("FAIL post_level: got %0d exp 1", LEVEL); end
  endtask

  initial begin
    CLK = 1'b0; RST = 1'b1; LED = '0; FLICK = 1'b0;
    test_reset();
    test_full_run();
    test_kick_seg0();
    test_kick_seg2();
    test_code_err();
    test_turn_stall();
    test_step_range();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
